// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter.
//   state_e  : arbiter FSM encoding
//   owner_e  : requester identity (FETCH = 0, DATA = 1)
//   acc_t    : per-access payload latched on the granting edge
package mem_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] MEM_SIZE = 16'h0100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e              owner;
        logic                we;
        logic [DATA_W-1:0]   wdata;
    } acc_t;

    // Unsigned range check against the memory depth.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < MEM_SIZE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
//   req[0]      : fetch request
//   req[1]      : data request
//   last_grant  : owner granted most recently
//   gnt_valid_c : a grant is available this cycle (combinational)
//   gnt_owner_c : owner to grant (combinational)
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_grant,
    output logic       gnt_valid_c,
    output owner_e     gnt_owner_c
);

    // On contention the requester that was not served last wins.
    always_comb begin
        gnt_valid_c = |req;
        gnt_owner_c = OWNER_FETCH;
        if (req[0] && req[1]) begin
            gnt_owner_c = (last_grant == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
        end else if (req[1]) begin
            gnt_owner_c = OWNER_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port 16-bit memory between the fetch unit (read only)
// and the data/stack unit (read/write), sequencing issue, wait, capture, ack.
//   clk, rst_n                     : clock, synchronous active-low reset
//   f_req/f_addr -> f_ack/f_rdata  : fetch port
//   d_req/d_we/d_addr/d_wdata
//     -> d_ack/d_rdata/d_err       : data port
//   mem_w/mem_addr/mem_wdata       : memory control (registered)
//   mem_rdata/mem_ready            : memory response
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

    state_e            state_q,      state_d;
    owner_e            last_grant_q, last_grant_d;
    acc_t              acc_q,        acc_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              f_ack_q,      f_ack_d;
    logic [DATA_W-1:0] f_rdata_q,    f_rdata_d;
    logic              d_ack_q,      d_ack_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              d_err_q,      d_err_d;
    logic              mem_w_q,      mem_w_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;

    logic              gnt_valid_c;
    owner_e            gnt_owner_c;
    logic              gnt_we_c;
    logic [ADDR_W-1:0] gnt_addr_c;
    logic [DATA_W-1:0] gnt_wdata_c;
    logic [DATA_W-1:0] cap_data_c;

    rr_arb2 u_rr_arb2 (
        .req         ({d_req, f_req}),
        .last_grant  (last_grant_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_owner_c (gnt_owner_c)
    );

    // Payload of the requester selected by the round-robin.
    always_comb begin
        gnt_we_c    = 1'b0;
        gnt_addr_c  = f_addr;
        gnt_wdata_c = '0;
        if (gnt_owner_c == OWNER_DATA) begin
            gnt_we_c    = d_we;
            gnt_addr_c  = d_addr;
            gnt_wdata_c = d_wdata;
        end
    end

    // A write returns the word it wrote; a read returns the memory word.
    assign cap_data_c = acc_q.we ? acc_q.wdata : mem_rdata;

    // Next-state and registered-output logic; acks are raised on entry to CAPTURE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        f_ack_d      = 1'b0;
        f_rdata_d    = f_rdata_q;
        d_ack_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_err_d      = 1'b0;
        mem_w_d      = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_c) begin
                    last_grant_d = gnt_owner_c;
                    acc_d.owner  = gnt_owner_c;
                    acc_d.we     = gnt_we_c;
                    acc_d.wdata  = gnt_wdata_c;
                    cnt_d        = '0;
                    if (addr_in_range(gnt_addr_c)) begin
                        state_d     = ST_ISSUE;
                        mem_addr_d  = gnt_addr_c;
                        mem_wdata_d = gnt_wdata_c;
                        mem_w_d     = gnt_we_c;
                    end else begin
                        // Out of range: skip the memory, complete with zero data.
                        state_d = ST_CAPTURE;
                        if (gnt_owner_c == OWNER_DATA) begin
                            d_ack_d   = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = '0;
                        end else begin
                            f_ack_d   = 1'b1;
                            f_rdata_d = '0;
                        end
                    end
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Ready is only trusted after the full wait has elapsed.
                if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    if (mem_ready) begin
                        state_d = ST_CAPTURE;
                        if (acc_q.owner == OWNER_DATA) begin
                            d_ack_d   = 1'b1;
                            d_rdata_d = cap_data_c;
                        end else begin
                            f_ack_d   = 1'b1;
                            f_rdata_d = cap_data_c;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWNER_DATA;
            acc_q        <= '0;
            cnt_q        <= '0;
            f_ack_q      <= 1'b0;
            f_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
            mem_w_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            f_ack_q      <= f_ack_d;
            f_rdata_q    <= f_rdata_d;
            d_ack_q      <= d_ack_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
            mem_w_q      <= mem_w_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign f_ack     = f_ack_q;
    assign f_rdata   = f_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_w     = mem_w_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        d_err;
    logic        mem_w;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ack     (f_ack),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_w     (mem_w),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: preloaded with 16'h1000 + addr; ready drops one edge
    // after an address change or a write.
    logic [15:0] mem [0:65535];
    logic        preloaded = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'h1000 + 16'(i);
            preloaded <= 1'b1;
        end else if (mem_w) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_ready <= !(mem_w || (mem_addr != prev_addr));
        prev_addr <= mem_addr;
    end

    assign mem_rdata = mem[mem_addr];

    // Event monitors: write strikes, acks, and grant order (1 = data).
    int       mem_w_cnt = 0;
    int       f_ack_cnt = 0;
    int       d_ack_cnt = 0;
    int       ack_n     = 0;
    logic [7:0] ack_seq = 8'h00;

    always @(posedge clk) begin
        if (mem_w) mem_w_cnt <= mem_w_cnt + 1;
        if (f_ack) f_ack_cnt <= f_ack_cnt + 1;
        if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
        if (f_ack || d_ack) begin
            ack_n   <= ack_n + 1;
            ack_seq <= {ack_seq[6:0], d_ack};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Cycles from raising a request until its ack is seen; 99 on timeout.
    task automatic wait_ack(input bit is_data, output int cycles);
        cycles = 0;
        while (!(is_data ? d_ack : f_ack) && cycles < 99) begin
            tick(1);
            cycles++;
        end
    endtask

    int c;
    int base;
    int guard;

    initial begin
        rst_n   = 1'b0;
        f_req   = 1'b1;
        f_addr  = 16'h0003;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;

        // 1. Reset with a pending fetch.
        tick(3);
        check("rst_f_ack",     16'(f_ack),     16'h0000);
        check("rst_d_ack",     16'(d_ack),     16'h0000);
        check("rst_d_err",     16'(d_err),     16'h0000);
        check("rst_mem_w",     16'(mem_w),     16'h0000);
        check("rst_mem_addr",  mem_addr,       16'h0000);
        check("rst_mem_wdata", mem_wdata,      16'h0000);
        check("rst_f_rdata",   f_rdata,        16'h0000);
        check("rst_d_rdata",   d_rdata,        16'h0000);
        check("rst_no_strike", 16'(mem_w_cnt), 16'h0000);
        check("rst_no_ack",    16'(f_ack_cnt + d_ack_cnt), 16'h0000);
        f_req = 1'b0;
        rst_n = 1'b1;
        tick(1);

        // 2. Write BEEF to 0x0010, then read it back.
        base    = mem_w_cnt;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0010;
        d_wdata = 16'hBEEF;
        wait_ack(1'b1, c);
        check("wr_latency", 16'(c),  16'd4);
        check("wr_d_err",   16'(d_err), 16'h0000);
        check("wr_rdata",   d_rdata, 16'hBEEF);
        d_req = 1'b0;
        tick(1);
        check("wr_ack_pulse", 16'(d_ack), 16'h0000);
        check("wr_strikes",   16'(mem_w_cnt - base), 16'd1);
        d_req = 1'b1;
        d_we  = 1'b0;
        wait_ack(1'b1, c);
        check("rd_latency", 16'(c),  16'd4);
        check("rd_rdata",   d_rdata, 16'hBEEF);
        d_req = 1'b0;
        tick(1);
        check("rd_strikes", 16'(mem_w_cnt - base), 16'd1);

        // 3. Simultaneous requests after reset, held: F, D, F, D.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        base   = ack_n;
        f_req  = 1'b1;
        f_addr = 16'h0003;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0010;
        guard  = 0;
        while ((ack_n - base) < 4 && guard < 100) begin
            tick(1);
            guard++;
        end
        f_req = 1'b0;
        d_req = 1'b0;
        check("rr_count",  16'(ack_n - base), 16'd4);
        check("rr_first",  16'(ack_seq[3]), 16'h0000);
        check("rr_second", 16'(ack_seq[2]), 16'h0001);
        check("rr_third",  16'(ack_seq[1]), 16'h0000);
        check("rr_fourth", 16'(ack_seq[0]), 16'h0001);
        check("rr_f_rdata", f_rdata, 16'h1003);
        check("rr_d_rdata", d_rdata, 16'hBEEF);
        tick(1);

        // 4. Out-of-range data read, then out-of-range fetch.
        base   = mem_w_cnt;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0100;
        wait_ack(1'b1, c);
        check("oor_latency",  16'(c),     16'd1);
        check("oor_d_err",    16'(d_err), 16'h0001);
        check("oor_d_rdata",  d_rdata,    16'h0000);
        check("oor_mem_addr", mem_addr,   16'h0010);
        d_req = 1'b0;
        tick(1);
        check("oor_err_pulse", 16'(d_err), 16'h0000);
        f_req  = 1'b1;
        f_addr = 16'hFFFF;
        wait_ack(1'b0, c);
        check("oorf_latency", 16'(c),   16'd1);
        check("oorf_rdata",   f_rdata,  16'h0000);
        check("oorf_mem_addr", mem_addr, 16'h0010);
        f_req = 1'b0;
        tick(1);
        check("oor_strikes", 16'(mem_w_cnt - base), 16'd0);

        // 5. Two fetches of 0x0003 back to back.
        f_req  = 1'b1;
        f_addr = 16'h0003;
        wait_ack(1'b0, c);
        check("ff1_latency", 16'(c),  16'd4);
        check("ff1_rdata",   f_rdata, 16'h1003);
        f_req = 1'b0;
        tick(1);
        f_req = 1'b1;
        wait_ack(1'b0, c);
        check("ff2_latency", 16'(c),  16'd4);
        check("ff2_rdata",   f_rdata, 16'h1003);
        f_req = 1'b0;
        tick(1);

        // 6. Write to 0x0020 interrupted by reset during WAIT.
        base    = d_ack_cnt;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0020;
        d_wdata = 16'h1234;
        tick(3);
        rst_n = 1'b0;
        d_req = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("abort_no_ack",   16'(d_ack_cnt - base), 16'd0);
        check("abort_mem_addr", mem_addr, 16'h0000);
        check("abort_d_rdata",  d_rdata,  16'h0000);
        d_req = 1'b1;
        d_we  = 1'b0;
        wait_ack(1'b1, c);
        check("post_latency", 16'(c),  16'd4);
        check("post_rdata",   d_rdata, 16'h1234);
        d_req = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
